ysyx_lsu_l1d: RTL and testbench
===============================

Name: ysyx_lsu_l1d

Overview:
Next-generation load/store unit with a parametrised, direct-mapped, write-through L1 data cache. It sits between the EXU and the memory bus arbiter. It accepts one load or store per request handshake and serves cacheable load hits in one cycle. Misses and uncached accesses go to the bus through a small FSM. Over the previous LSU it adds:
- store-hit write-update, replacing invalidate;
- byte-lane store alignment;
- misalignment detection;
- a whole-cache flush.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data/bus word width (byte-lane logic assumes 32)
L1D_LINES, 64, number of one-word lines (power of 2, ≥2)
CACHE_BASE, 32'h8000_0000, first cacheable byte address
CACHE_LIMIT, 32'h8040_0000, first non-cacheable address above base

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
req_valid  in  1  EXU request valid
req_ready  out  1  LSU can accept a request
req_wen  in  1  1 = store, 0 = load
req_op  in  4  ysyx_ALU_OP_{LB,LBU,LH,LHU,LW,SB,SH,SW}
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data, LSB-aligned
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  DATA_W  load result, extended per op
resp_err  out  1  misaligned access (valid with resp_valid)
flush  in  1  invalidate all lines
bus_araddr  out  ADDR_W  read address
bus_arvalid  out  1  read request
bus_rstrb  out  8  read strobe, shifted to byte lane
bus_rdata  in  DATA_W  aligned word containing araddr
bus_rvalid  in  1  read data valid (single cycle)
bus_awaddr  out  ADDR_W  write address
bus_awvalid  out  1  write address valid
bus_wdata  out  DATA_W  lane-shifted store data
bus_wstrb  out  8  lane-shifted byte enables
bus_wvalid  out  1  write data valid
bus_wready  in  1  write accepted

Behaviour:
- Reset (async):
  - state = IDLE; all valid bits = 0.
  - resp_valid = 0, resp_err = 0, resp_rdata = 0.
  - All bus valids = 0; bus address/data registers = 0.
  - req_ready = 1 after reset release.
  - Tag and data arrays are not reset.
- Address split: idx = addr[log2(L1D_LINES)+1:2]; tag = addr[ADDR_W-1:log2(L1D_LINES)+2]. Cacheable iff CACHE_BASE ≤ addr < CACHE_LIMIT.
- Request acceptance: a request is accepted when req_valid & req_ready. req_ready = (state==IDLE). The address, op, wen and wdata are registered at acceptance.
- Misalignment rule: misaligned iff LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
  - A misaligned request goes to RESP: resp_err=1, no bus traffic, no cache change.
- FSM states: IDLE, LOOKUP, RD_WAIT, WR_WAIT, RESP.
  - IDLE → LOOKUP on accept.
  - LOOKUP, load, cacheable, hit (valid & tag equal): RESP, data taken from the array. Total latency is 2 cycles from accept to resp_valid.
  - LOOKUP, load, miss or uncached: RD_WAIT. bus_arvalid=1 is held until bus_rvalid.
  - RD_WAIT: on bus_rvalid, capture data.
    - If cacheable, fill: line data = bus_rdata, tag written, valid = 1.
    - Then RESP.
  - LOOKUP, store: WR_WAIT. bus_awvalid = bus_wvalid = 1, held until bus_wready.
  - WR_WAIT: on bus_wready:
    - if the address is cacheable and hits, merge the wstrb bytes into the line (valid stays 1);
    - a miss does not allocate;
    - then RESP.
  - RESP: resp_valid=1 for exactly one cycle, then IDLE. req_ready is low in RESP, so there is no back-to-back accept.
- Load extraction: word >> 8*addr[1:0], then:
  - LB/LH sign-extend from bit 7/15;
  - LBU/LHU zero-extend;
  - LW passes through.
  - resp_rdata = 0 for stores and errors.
- Store lanes:
  - bus_wdata = wdata << 8*addr[1:0].
  - bus_wstrb = base strobe (SB 1, SH 3, SW F) << addr[1:0].
  - bus_rstrb is formed the same way.
- flush:
  - In any state it clears all valid bits in that cycle.
  - If flush coincides with a fill or store-merge, flush wins and the line ends invalid.
  - flush does not abort an in-flight bus transaction.
- Reset mid-transaction: bus valids drop immediately (async), and no response is issued for the aborted request.
- The bus address and data outputs are stable while their valid is high.

Decomposition:
- Shared package (ysyx_macro.v): ysyx_ALU_OP_* encodings, and the CACHE_BASE/CACHE_LIMIT defaults as macros.
- Sub-module ysyx_lsu_align: purely combinational. It contains:
  - the load extract/extend logic;
  - the store lane shift, strobe generation and misalign detect.
- The top level holds the FSM and the tag/data/valid arrays.

Test Plan:
- LW 0x8000_0010, bus returns 0xDEAD_BEEF: one arvalid, resp 0xDEAD_BEEF. A repeated LW makes no bus read, resp_valid 2 cycles after accept, same data.
- LB at 0x8000_0013 after the fill above → 0xFFFF_FFDE. LBU at the same address → 0x0000_00DE. LHU at 0x8000_0012 → 0x0000_DEAD.
- SB 0x8000_0011, wdata 0x55 (line cached) → bus_wdata 0x0000_5500, wstrb 0x2. A following LW hits and returns 0xDEAD_55EF.
- LW at 0x1000_0000 (uncached) twice → two bus reads, no fill. LH at 0x8000_0001 → resp_err=1, no bus valid.
- Fill at 0x8000_0010, then flush, then LW at 0x8000_0010 → miss and bus read. Fill 0x8000_0010, then LW 0x8000_0110 (same idx, different tag) → miss, and the line is replaced.
- Assert rst during RD_WAIT → arvalid=0 immediately, no resp_valid. After release a LW to the previously filled address misses.

Source files
------------

// File: rtl/ysyx_lsu_l1d_pkg.sv
// Shared definitions for the L1D load/store unit: op encodings, cacheable
// window defaults, FSM state type and the base byte-strobe helper.
package ysyx_lsu_l1d_pkg;

  localparam logic [3:0] ysyx_ALU_OP_LB  = 4'd0;
  localparam logic [3:0] ysyx_ALU_OP_LBU = 4'd1;
  localparam logic [3:0] ysyx_ALU_OP_LH  = 4'd2;
  localparam logic [3:0] ysyx_ALU_OP_LHU = 4'd3;
  localparam logic [3:0] ysyx_ALU_OP_LW  = 4'd4;
  localparam logic [3:0] ysyx_ALU_OP_SB  = 4'd5;
  localparam logic [3:0] ysyx_ALU_OP_SH  = 4'd6;
  localparam logic [3:0] ysyx_ALU_OP_SW  = 4'd7;

  localparam logic [31:0] CACHE_BASE_DEF  = 32'h8000_0000;
  localparam logic [31:0] CACHE_LIMIT_DEF = 32'h8040_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_RD_WAIT,
    ST_WR_WAIT,
    ST_RESP
  } lsu_state_e;

  // Byte enables of an access before it is shifted onto its byte lane.
  function automatic logic [3:0] base_strb(input logic [3:0] op);
    case (op)
      ysyx_ALU_OP_LB, ysyx_ALU_OP_LBU, ysyx_ALU_OP_SB: base_strb = 4'b0001;
      ysyx_ALU_OP_LH, ysyx_ALU_OP_LHU, ysyx_ALU_OP_SH: base_strb = 4'b0011;
      default:                                         base_strb = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_lsu_l1d_align.sv
// Combinational byte-lane logic: load extract/extend, store lane shift,
// strobe generation and misalignment detection.
module ysyx_lsu_l1d_align
  import ysyx_lsu_l1d_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [31:0] load_o,
  output logic [31:0] wdata_o,
  output logic [7:0]  strb_o,
  output logic        misalign_o
);

  logic [31:0] shifted;

  assign shifted = rword_i >> {off_i, 3'b000};

  always_comb begin
    load_o = shifted;
    case (op_i)
      ysyx_ALU_OP_LB:  load_o = {{24{shifted[7]}}, shifted[7:0]};
      ysyx_ALU_OP_LBU: load_o = {24'd0, shifted[7:0]};
      ysyx_ALU_OP_LH:  load_o = {{16{shifted[15]}}, shifted[15:0]};
      ysyx_ALU_OP_LHU: load_o = {16'd0, shifted[15:0]};
      default:         load_o = shifted;
    endcase
  end

  assign wdata_o = wdata_i << {off_i, 3'b000};
  assign strb_o  = {4'd0, base_strb(op_i)} << off_i;

  always_comb begin
    misalign_o = 1'b0;
    case (op_i)
      ysyx_ALU_OP_LH, ysyx_ALU_OP_LHU, ysyx_ALU_OP_SH: misalign_o = off_i[0];
      ysyx_ALU_OP_LW, ysyx_ALU_OP_SW:                  misalign_o = |off_i;
      default:                                         misalign_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ysyx_lsu_l1d.sv
// Load/store unit with a direct-mapped, write-through, one-word-per-line
// L1 data cache; misses and uncached accesses go to the bus via the FSM.
module ysyx_lsu_l1d
  import ysyx_lsu_l1d_pkg::*;
#(
  parameter int              ADDR_W      = 32,
  parameter int              DATA_W      = 32,
  parameter int              L1D_LINES   = 64,
  parameter logic [ADDR_W-1:0] CACHE_BASE  = ADDR_W'(CACHE_BASE_DEF),
  parameter logic [ADDR_W-1:0] CACHE_LIMIT = ADDR_W'(CACHE_LIMIT_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  input  logic              flush,
  output logic [ADDR_W-1:0] bus_araddr,
  output logic              bus_arvalid,
  output logic [7:0]        bus_rstrb,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_rvalid,
  output logic [ADDR_W-1:0] bus_awaddr,
  output logic              bus_awvalid,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [7:0]        bus_wstrb,
  output logic              bus_wvalid,
  input  logic              bus_wready
);

  localparam int IDX_W = $clog2(L1D_LINES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        op_q;
  logic              wen_q;
  logic [DATA_W-1:0] wdata_q;

  logic              resp_valid_q, resp_err_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic [ADDR_W-1:0] bus_araddr_q, bus_awaddr_q;
  logic              bus_arvalid_q, bus_awvalid_q, bus_wvalid_q;
  logic [7:0]        bus_rstrb_q, bus_wstrb_q;
  logic [DATA_W-1:0] bus_wdata_q;

  logic [TAG_W-1:0]  tag_mem [L1D_LINES];
  logic [DATA_W-1:0] data_mem [L1D_LINES];
  logic [L1D_LINES-1:0] valid_q;
  logic [TAG_W-1:0]  tag_rd_q;
  logic [DATA_W-1:0] data_rd_q;

  logic              accept, cacheable, hit, misalign, fill_we, merge_we;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [31:0]       load_data, lane_wdata, rword;
  logic [7:0]        lane_strb;
  logic [DATA_W-1:0] merged;

  assign accept    = req_valid & req_ready;
  assign idx       = addr_q[IDX_W+1:2];
  assign tag       = addr_q[ADDR_W-1:IDX_W+2];
  assign cacheable = (addr_q >= CACHE_BASE) && (addr_q < CACHE_LIMIT);
  // The tag/data read registered at accept stays coherent: only this
  // request can write the line before it completes.
  assign hit       = cacheable & valid_q[idx] & (tag_rd_q == tag);
  assign fill_we   = (state_q == ST_RD_WAIT) & bus_rvalid & cacheable;
  assign merge_we  = (state_q == ST_WR_WAIT) & bus_wready & hit;
  assign rword     = (state_q == ST_LOOKUP) ? data_rd_q : bus_rdata;

  ysyx_lsu_l1d_align u_align (
    .op_i       (op_q),
    .off_i      (addr_q[1:0]),
    .wdata_i    (wdata_q),
    .rword_i    (rword),
    .load_o     (load_data),
    .wdata_o    (lane_wdata),
    .strb_o     (lane_strb),
    .misalign_o (misalign)
  );

  for (genvar gi = 0; gi < 4; gi++) begin : g_merge
    assign merged[8*gi +: 8] = lane_strb[gi] ? lane_wdata[8*gi +: 8] : data_rd_q[8*gi +: 8];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (req_valid) state_d = ST_LOOKUP;
      ST_LOOKUP: begin
        if (misalign)   state_d = ST_RESP;
        else if (wen_q) state_d = ST_WR_WAIT;
        else if (hit)   state_d = ST_RESP;
        else            state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: if (bus_rvalid) state_d = ST_RESP;
      ST_WR_WAIT: if (bus_wready) state_d = ST_RESP;
      ST_RESP:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      op_q          <= '0;
      wen_q         <= 1'b0;
      wdata_q       <= '0;
      resp_valid_q  <= 1'b0;
      resp_err_q    <= 1'b0;
      resp_rdata_q  <= '0;
      bus_araddr_q  <= '0;
      bus_arvalid_q <= 1'b0;
      bus_rstrb_q   <= '0;
      bus_awaddr_q  <= '0;
      bus_awvalid_q <= 1'b0;
      bus_wdata_q   <= '0;
      bus_wstrb_q   <= '0;
      bus_wvalid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= (state_d == ST_RESP);
      if (accept) begin
        addr_q  <= req_addr;
        op_q    <= req_op;
        wen_q   <= req_wen;
        wdata_q <= req_wdata;
      end
      case (state_q)
        ST_LOOKUP: begin
          resp_err_q   <= misalign;
          resp_rdata_q <= '0;
          if (!misalign) begin
            if (wen_q) begin
              bus_awvalid_q <= 1'b1;
              bus_wvalid_q  <= 1'b1;
              bus_awaddr_q  <= addr_q;
              bus_wdata_q   <= lane_wdata;
              bus_wstrb_q   <= lane_strb;
            end else if (hit) begin
              resp_rdata_q <= load_data;
            end else begin
              bus_arvalid_q <= 1'b1;
              bus_araddr_q  <= addr_q;
              bus_rstrb_q   <= lane_strb;
            end
          end
        end
        ST_RD_WAIT: if (bus_rvalid) begin
          bus_arvalid_q <= 1'b0;
          resp_rdata_q  <= load_data;
        end
        ST_WR_WAIT: if (bus_wready) begin
          bus_awvalid_q <= 1'b0;
          bus_wvalid_q  <= 1'b0;
        end
        ST_RESP: resp_err_q <= 1'b0;
        default: ;
      endcase
    end
  end

  // Flush has priority so a line filled or merged in the same cycle ends invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          valid_q <= '0;
    else if (flush)   valid_q <= '0;
    else if (fill_we) valid_q[idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_mem[idx]  <= tag;
      data_mem[idx] <= bus_rdata;
    end else if (merge_we) begin
      data_mem[idx] <= merged;
    end
    if (accept) begin
      tag_rd_q  <= tag_mem[req_addr[IDX_W+1:2]];
      data_rd_q <= data_mem[req_addr[IDX_W+1:2]];
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign resp_valid  = resp_valid_q;
  assign resp_err    = resp_err_q;
  assign resp_rdata  = resp_rdata_q;
  assign bus_araddr  = bus_araddr_q;
  assign bus_arvalid = bus_arvalid_q;
  assign bus_rstrb   = bus_rstrb_q;
  assign bus_awaddr  = bus_awaddr_q;
  assign bus_awvalid = bus_awvalid_q;
  assign bus_wdata   = bus_wdata_q;
  assign bus_wstrb   = bus_wstrb_q;
  assign bus_wvalid  = bus_wvalid_q;

endmodule

// File: tb/tb_ysyx_lsu_l1d.sv
// Scoreboard bench for ysyx_lsu_l1d: a responding bus model drives each
// request to completion and expected responses are popped on resp_valid.
module tb_ysyx_lsu_l1d;
  import ysyx_lsu_l1d_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_wen = 1'b0, flush = 1'b0;
  logic [3:0]  req_op = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] bus_araddr, bus_awaddr, bus_wdata;
  logic        bus_arvalid, bus_awvalid, bus_wvalid;
  logic [7:0]  bus_rstrb, bus_wstrb;
  logic [31:0] bus_rdata = '0;
  logic        bus_rvalid = 1'b0, bus_wready = 1'b0;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ysyx_lsu_l1d dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .flush(flush),
    .bus_araddr(bus_araddr), .bus_arvalid(bus_arvalid), .bus_rstrb(bus_rstrb),
    .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid),
    .bus_awaddr(bus_awaddr), .bus_awvalid(bus_awvalid), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_wvalid(bus_wvalid), .bus_wready(bus_wready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_strb(input logic [3:0] op, input logic [1:0] off);
    logic [7:0] b;
    case (op)
      ysyx_ALU_OP_LB, ysyx_ALU_OP_LBU, ysyx_ALU_OP_SB: b = 8'h01;
      ysyx_ALU_OP_LH, ysyx_ALU_OP_LHU, ysyx_ALU_OP_SH: b = 8'h03;
      default:                                         b = 8'h0F;
    endcase
    return b << off;
  endfunction

  // Issue one request, act as the bus, and compare the response against
  // the scoreboard entry. exp_lat=0 skips the latency check.
  task automatic run_req(input string name, input logic wen, input logic [3:0] op,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] bdata, input logic [31:0] exp_rdata,
                         input logic exp_err, input int exp_reads, input int exp_writes,
                         input logic [31:0] exp_wdata, input logic [7:0] exp_wstrb,
                         input int exp_lat, input logic fl_on_bus);
    exp_t e;
    int   cycles, reads, writes;
    bit   done;
    @(negedge clk);
    check({name, ".ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_wen = wen; req_op = op; req_addr = addr; req_wdata = wdata;
    exp_q.push_back('{err: exp_err, rdata: exp_rdata});
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    cycles = 1; reads = 0; writes = 0; done = 1'b0;
    while (!done && cycles < 50) begin
      flush = 1'b0;
      if (resp_valid) begin
        done = 1'b1;
        if (exp_q.size() == 0) begin
          check({name, ".unexpected_resp"}, 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check({name, ".rdata"}, resp_rdata, e.rdata);
          check({name, ".err"}, {31'd0, resp_err}, {31'd0, e.err});
        end
        if (exp_lat != 0) check({name, ".latency"}, cycles, exp_lat);
      end
      if (bus_arvalid && !bus_rvalid) begin
        reads++;
        check({name, ".araddr"}, bus_araddr, addr);
        check({name, ".rstrb"}, {24'd0, bus_rstrb}, {24'd0, model_strb(op, addr[1:0])});
        bus_rdata = bdata; bus_rvalid = 1'b1; flush = fl_on_bus;
      end else begin
        bus_rvalid = 1'b0;
      end
      if (bus_awvalid && bus_wvalid && !bus_wready) begin
        writes++;
        check({name, ".awaddr"}, bus_awaddr, addr);
        check({name, ".wdata"}, bus_wdata, exp_wdata);
        check({name, ".wstrb"}, {24'd0, bus_wstrb}, {24'd0, exp_wstrb});
        bus_wready = 1'b1; flush = fl_on_bus;
      end else begin
        bus_wready = 1'b0;
      end
      if (!done) begin
        @(posedge clk);
        cycles++;
        @(negedge clk);
      end
    end
    bus_rvalid = 1'b0; bus_wready = 1'b0; flush = 1'b0;
    if (!done) begin
      check({name, ".timeout"}, 32'd1, 32'd0);
      void'(exp_q.pop_back());
    end
    check({name, ".reads"}, reads, exp_reads);
    check({name, ".writes"}, writes, exp_writes);
    $display("txn %-12s wen=%0d op=%0d addr=%h rdata=%h err=%0d reads=%0d writes=%0d lat=%0d",
             name, wen, op, addr, resp_rdata, resp_err, reads, writes, cycles);
  endtask

  task automatic ld(input string name, input logic [3:0] op, input logic [31:0] addr,
                    input logic [31:0] bdata, input logic [31:0] exp_rdata,
                    input int exp_reads, input int exp_lat);
    run_req(name, 1'b0, op, addr, 32'd0, bdata, exp_rdata, 1'b0, exp_reads, 0,
            32'd0, 8'd0, exp_lat, 1'b0);
  endtask

  task automatic st(input string name, input logic [3:0] op, input logic [31:0] addr,
                    input logic [31:0] wdata, input logic [31:0] exp_wdata,
                    input logic [7:0] exp_wstrb);
    run_req(name, 1'b1, op, addr, wdata, 32'd0, 32'd0, 1'b0, 0, 1, exp_wdata, exp_wstrb,
            0, 1'b0);
  endtask

  initial begin
    int seen_ar, resp_cnt;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst.arvalid", {31'd0, bus_arvalid}, 32'd0);
    check("rst.awvalid", {31'd0, bus_awvalid}, 32'd0);
    check("rst.resp_rdata", resp_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst.req_ready", {31'd0, req_ready}, 32'd1);

    // Fill, hit and sub-word extraction
    ld("lw_fill",  ysyx_ALU_OP_LW,  32'h8000_0010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 0);
    ld("lw_hit",   ysyx_ALU_OP_LW,  32'h8000_0010, 32'h0,         32'hDEAD_BEEF, 0, 2);
    ld("lb_hit",   ysyx_ALU_OP_LB,  32'h8000_0013, 32'h0,         32'hFFFF_FFDE, 0, 2);
    ld("lbu_hit",  ysyx_ALU_OP_LBU, 32'h8000_0013, 32'h0,         32'h0000_00DE, 0, 2);
    ld("lhu_hit",  ysyx_ALU_OP_LHU, 32'h8000_0012, 32'h0,         32'h0000_DEAD, 0, 2);
    ld("lh_hit",   ysyx_ALU_OP_LH,  32'h8000_0012, 32'h0,         32'hFFFF_DEAD, 0, 2);
    ld("lb_pos",   ysyx_ALU_OP_LB,  32'h8000_0011, 32'h0,         32'hFFFF_FFBE, 0, 2);

    // Store-hit write-update with lane shifting
    st("sb_hit", ysyx_ALU_OP_SB, 32'h8000_0011, 32'h0000_0055, 32'h0000_5500, 8'h02);
    ld("lw_after_sb", ysyx_ALU_OP_LW, 32'h8000_0010, 32'h0, 32'hDEAD_55EF, 0, 2);
    st("sh_hit", ysyx_ALU_OP_SH, 32'h8000_0012, 32'h0000_1234, 32'h1234_0000, 8'h0C);
    ld("lw_after_sh", ysyx_ALU_OP_LW, 32'h8000_0010, 32'h0, 32'h1234_55EF, 0, 2);
    st("sw_miss", ysyx_ALU_OP_SW, 32'h8000_0040, 32'hCAFE_F00D, 32'hCAFE_F00D, 8'h0F);
    ld("lw_no_alloc", ysyx_ALU_OP_LW, 32'h8000_0040, 32'h1111_2222, 32'h1111_2222, 1, 0);

    // Uncached window and its edges
    ld("unc_1",    ysyx_ALU_OP_LW, 32'h1000_0000, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1, 0);
    ld("unc_2",    ysyx_ALU_OP_LW, 32'h1000_0000, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 1, 0);
    ld("limit_1",  ysyx_ALU_OP_LW, 32'h8040_0000, 32'h0000_0001, 32'h0000_0001, 1, 0);
    ld("limit_2",  ysyx_ALU_OP_LW, 32'h8040_0000, 32'h0000_0002, 32'h0000_0002, 1, 0);
    ld("top_fill", ysyx_ALU_OP_LW, 32'h803F_FFFC, 32'h7777_8888, 32'h7777_8888, 1, 0);
    ld("top_hit",  ysyx_ALU_OP_LW, 32'h803F_FFFC, 32'h0,         32'h7777_8888, 0, 2);
    ld("lbu_unc",  ysyx_ALU_OP_LBU, 32'h1000_0002, 32'h00AB_0000, 32'h0000_00AB, 1, 0);

    // Misalignment: error response, no bus traffic
    run_req("lh_mis", 1'b0, ysyx_ALU_OP_LH, 32'h8000_0001, 32'h0, 32'h0, 32'h0, 1'b1,
            0, 0, 32'h0, 8'h0, 2, 1'b0);
    run_req("sw_mis", 1'b1, ysyx_ALU_OP_SW, 32'h8000_0012, 32'hFFFF_FFFF, 32'h0, 32'h0,
            1'b1, 0, 0, 32'h0, 8'h0, 2, 1'b0);
    run_req("lw_mis", 1'b0, ysyx_ALU_OP_LW, 32'h8000_0003, 32'h0, 32'h0, 32'h0, 1'b1,
            0, 0, 32'h0, 8'h0, 2, 1'b0);
    ld("lw_after_err", ysyx_ALU_OP_LW, 32'h8000_0010, 32'h0, 32'h1234_55EF, 0, 2);

    // Flush in idle, then flush colliding with a fill
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    ld("lw_flushed", ysyx_ALU_OP_LW, 32'h8000_0010, 32'h0102_0304, 32'h0102_0304, 1, 0);
    run_req("fill_flush", 1'b0, ysyx_ALU_OP_LW, 32'h8000_0020, 32'h0, 32'h3333_4444,
            32'h3333_4444, 1'b0, 1, 0, 32'h0, 8'h0, 0, 1'b1);
    ld("lw_fl_miss", ysyx_ALU_OP_LW, 32'h8000_0020, 32'h5555_6666, 32'h5555_6666, 1, 0);

    // Conflict replacement on the same index
    ld("conf_new", ysyx_ALU_OP_LW, 32'h8000_0110, 32'h0BAD_F00D, 32'h0BAD_F00D, 1, 0);
    ld("conf_hit", ysyx_ALU_OP_LW, 32'h8000_0110, 32'h0,         32'h0BAD_F00D, 0, 2);
    ld("conf_old", ysyx_ALU_OP_LW, 32'h8000_0010, 32'h0102_0304, 32'h0102_0304, 1, 0);
    ld("conf_re",  ysyx_ALU_OP_LW, 32'h8000_0010, 32'h0,         32'h0102_0304, 0, 2);

    // Reset while a read is outstanding
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b0; req_op = ysyx_ALU_OP_LW; req_addr = 32'h8000_0030;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    seen_ar = 0;
    for (int i = 0; i < 10 && seen_ar == 0; i++) begin
      if (bus_arvalid) seen_ar = 1;
      else @(negedge clk);
    end
    check("mid.arvalid_seen", seen_ar, 1);
    rst = 1'b1;
    #1;
    check("mid.arvalid_drop", {31'd0, bus_arvalid}, 32'd0);
    check("mid.resp_valid", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    resp_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (resp_valid) resp_cnt++;
    end
    check("mid.no_resp", resp_cnt, 0);
    ld("post_rst", ysyx_ALU_OP_LW, 32'h8000_0010, 32'h0A0B_0C0D, 32'h0A0B_0C0D, 1, 0);
    ld("post_hit", ysyx_ALU_OP_LW, 32'h8000_0010, 32'h0,         32'h0A0B_0C0D, 0, 2);

    check("sb.empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
